// File: rtl/hamming_decoder_pkg.sv
// +----------------------------------------------------------------------------+
// | hamming_decoder_pkg : shared widths, bit maps and syndrome helper           |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

package hamming_decoder_pkg;

  localparam int CODE_W = 21;
  localparam int DATA_W = 16;
  localparam int PAR_W  = 5;

  localparam int PAR_POS [PAR_W]   = '{0, 1, 3, 7, 15};
  localparam int DATA_IDX [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14,
                                       16, 17, 18, 19, 20};

  // Largest syndrome that still names a real codeword position.
  localparam logic [PAR_W-1:0] MAX_CORR_SYN = PAR_W'(CODE_W);

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [PAR_W-1:0]  syn_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              corrected;
    logic              uncorrectable;
    syn_t              syndrome;
  } dec_out_t;

  function automatic syn_t calc_syndrome(input code_t code);
    syn_t s;
    s = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (code[i]) s = s ^ PAR_W'(i + 1);
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hamming_decoder_if.sv
// +----------------------------------------------------------------------------+
// | hamming_decoder_if : codeword input stream and decoded output stream        |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

interface hamming_decoder_if;
  import hamming_decoder_pkg::*;

  logic              in_valid;
  logic              in_ready;
  code_t             code_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              corrected;
  logic              uncorrectable;
  syn_t              syndrome;

  modport master (
    output in_valid, code_in, out_ready,
    input  in_ready, out_valid, data_out, corrected, uncorrectable, syndrome
  );

  modport slave (
    input  in_valid, code_in, out_ready,
    output in_ready, out_valid, data_out, corrected, uncorrectable, syndrome
  );

endinterface

`default_nettype wire

// File: rtl/hamming_syndrome.sv
// +----------------------------------------------------------------------------+
// | hamming_syndrome : combinational syndrome, single-bit correct and extract   |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module hamming_syndrome
  import hamming_decoder_pkg::*;
(
  input  code_t    calc_code,
  output syn_t     calc_syn,
  input  code_t    fix_code,
  input  syn_t     fix_syn,
  output dec_out_t fix_out
);

  code_t             fixed;
  logic [DATA_W-1:0] data_x;

  always_comb begin
    calc_syn = calc_syndrome(calc_code);
  end

  // Syndromes past the last position match no index, so nothing flips.
  always_comb begin
    fixed = fix_code;
    for (int i = 0; i < CODE_W; i++) begin
      if (fix_syn == PAR_W'(i + 1)) fixed[i] = ~fix_code[i];
    end
  end

  for (genvar k = 0; k < DATA_W; k++) begin : g_extract
    assign data_x[k] = fixed[DATA_IDX[k]];
  end

  always_comb begin
    fix_out               = '0;
    fix_out.data          = data_x;
    fix_out.syndrome      = fix_syn;
    fix_out.corrected     = (fix_syn != '0) && (fix_syn <= MAX_CORR_SYN);
    fix_out.uncorrectable = (fix_syn > MAX_CORR_SYN);
  end

endmodule

`default_nettype wire

// File: rtl/hamming_decoder.sv
// +----------------------------------------------------------------------------+
// | hamming_decoder : two-stage SEC Hamming(21,16) decoder with error counters  |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module hamming_decoder
  import hamming_decoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  hamming_decoder_if.slave       bus,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       corr_cnt,
  output logic [CNT_W-1:0]       uncorr_cnt
);

  logic             s1_valid_q, s1_valid_d;
  code_t            s1_code_q, s1_code_d;
  syn_t             s1_syn_q, s1_syn_d;
  logic             s2_valid_q, s2_valid_d;
  dec_out_t         s2_out_q, s2_out_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  logic     s1_adv;
  logic     s2_adv;
  logic     out_fire;
  syn_t     calc_syn;
  dec_out_t fix_out;

  hamming_syndrome u_syndrome (
    .calc_code (bus.code_in),
    .calc_syn  (calc_syn),
    .fix_code  (s1_code_q),
    .fix_syn   (s1_syn_q),
    .fix_out   (fix_out)
  );

  always_comb begin
    s2_adv   = !s2_valid_q || bus.out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    out_fire = s2_valid_q && bus.out_ready;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_code_d = bus.code_in;
        s1_syn_d  = calc_syn;
      end
    end
  end

  // Output payload only moves when S1 actually hands a word over, so it
  // stays frozen while the consumer stalls.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_out_d   = s2_out_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_out_d = fix_out;
    end
  end

  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_fire) begin
      if (s2_out_q.corrected && (corr_cnt_q != '1))
        corr_cnt_d = corr_cnt_q + CNT_W'(1);
      if (s2_out_q.uncorrectable && (uncorr_cnt_q != '1))
        uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_syn_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_out_q     <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_code_q    <= s1_code_d;
      s1_syn_q     <= s1_syn_d;
      s2_valid_q   <= s2_valid_d;
      s2_out_q     <= s2_out_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign bus.in_ready      = s1_adv;
  assign bus.out_valid     = s2_valid_q;
  assign bus.data_out      = s2_out_q.data;
  assign bus.corrected     = s2_out_q.corrected;
  assign bus.uncorrectable = s2_out_q.uncorrectable;
  assign bus.syndrome      = s2_out_q.syndrome;
  assign corr_cnt          = corr_cnt_q;
  assign uncorr_cnt        = uncorr_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hamming_decoder.sv
// +----------------------------------------------------------------------------+
// | tb_hamming_decoder : randomized self-checking bench for hamming_decoder     |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hamming_decoder;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [15:0] data;
    logic [4:0]  syn;
    logic        corr;
    logic        unc;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             cnt_clr;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  hamming_decoder_if bus ();

  hamming_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];
  int   exp_corr = 0;
  int   exp_unc  = 0;
  exp_t held;
  bit   held_valid = 0;
  bit   accepted   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: syndrome is the XOR of 1-based positions of set bits; data
  // bits are the non-power-of-two positions in ascending order.
  function automatic exp_t ref_dec(input logic [20:0] c);
    exp_t        r;
    int          s;
    int          k;
    logic [20:0] f;
    s = 0;
    for (int p = 1; p <= 21; p++) if (c[p-1]) s = s ^ p;
    f = c;
    if (s >= 1 && s <= 21) f[s-1] = ~f[s-1];
    k = 0;
    r = '0;
    for (int p = 1; p <= 21; p++) begin
      if ((p & (p - 1)) != 0) begin
        r.data[k] = f[p-1];
        k++;
      end
    end
    r.syn  = 5'(s);
    r.corr = (s >= 1 && s <= 21);
    r.unc  = (s >= 22);
    return r;
  endfunction

  task automatic tick();
    exp_t e;
    exp_t got;
    @(negedge clk);
    chk("corr_cnt", 32'(corr_cnt), 32'(exp_corr));
    chk("uncorr_cnt", 32'(uncorr_cnt), 32'(exp_unc));
    got      = '0;
    got.data = bus.data_out;
    got.syn  = bus.syndrome;
    got.corr = bus.corrected;
    got.unc  = bus.uncorrectable;
    if (held_valid) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_hold", 32'(got), 32'(held));
    end
    held_valid = 0;
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else if (bus.out_ready) begin
        e = q.pop_front();
        chk("data_out", 32'(got.data), 32'(e.data));
        chk("syndrome", 32'(got.syn), 32'(e.syn));
        chk("corrected", 32'(got.corr), 32'(e.corr));
        chk("uncorrectable", 32'(got.unc), 32'(e.unc));
        if (e.corr && exp_corr < CNT_MAX) exp_corr++;
        if (e.unc && exp_unc < CNT_MAX) exp_unc++;
      end
      if (!bus.out_ready) begin
        held       = got;
        held_valid = 1;
      end
    end
    if (cnt_clr) begin
      exp_corr = 0;
      exp_unc  = 0;
    end
    accepted = bus.in_valid && bus.in_ready;
    if (accepted) q.push_back(ref_dec(bus.code_in));
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [20:0] code);
    bus.in_valid = 1'b1;
    bus.code_in  = code;
    accepted     = 0;
    for (int i = 0; i < 50 && !accepted; i++) tick();
    if (!accepted) chk("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    int         sent;
    int         n;

    rst           = 1'b0;
    cnt_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.code_in   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_syn", 32'(bus.syndrome), 32'd0);
    chk("rst_flags", {30'd0, bus.corrected, bus.uncorrectable}, 32'd0);
    chk("rst_cnts", {corr_cnt, uncorr_cnt}, 32'd0);
    rst = 1'b1;
    #1;
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Latency with out_ready held high: all-zero codeword.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.code_in   = 21'h000000;
    tick();
    bus.in_valid = 1'b0;
    chk("latency_c1", 32'(bus.out_valid), 32'd0);
    tick();
    chk("latency_c2", 32'(bus.out_valid), 32'd1);
    chk("zero_data", 32'(bus.data_out), 32'h0000);
    drain();

    send_one(21'h000020);
    drain();
    chk("single_err_cnt", 32'(corr_cnt), 32'd1);

    send_one(21'h020010);
    drain();
    chk("uncorr_cnt_1", 32'(uncorr_cnt), 32'd1);
    chk("corr_cnt_kept", 32'(corr_cnt), 32'd1);

    // Eight words with out_ready cycling 1,0,0,1.
    pat  = 4'b1001;
    sent = 0;
    n    = 0;
    bus.in_valid = 1'b1;
    bus.code_in  = 21'($urandom);
    while ((sent < 8 || q.size() != 0) && n < 200) begin
      bus.out_ready = pat[n % 4];
      tick();
      if (accepted) begin
        sent++;
        bus.code_in = 21'($urandom);
      end
      if (sent >= 8) bus.in_valid = 1'b0;
      n++;
    end
    if (n >= 200) chk("stream_timeout", 32'd0, 32'd1);
    drain();

    // Saturate corr_cnt, then clear while an increment fires.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.code_in   = 21'h000001;
    repeat (22) tick();
    chk("corr_sat", 32'(corr_cnt), 32'(CNT_MAX));
    chk("clr_during_fire", 32'(bus.out_valid && bus.corrected), 32'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr      = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_priority", 32'(corr_cnt), 32'd0);
    drain();

    // Randomized traffic.
    bus.in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.in_valid || accepted) begin
        bus.in_valid = ($urandom % 4) != 0;
        case ($urandom % 3)
          0:       bus.code_in = 21'($urandom);
          1:       bus.code_in = 21'(1 << ($urandom % 21));
          default: bus.code_in = 21'($urandom) & 21'h0000FF;
        endcase
      end
      bus.out_ready = ($urandom % 3) != 0;
      cnt_clr       = ($urandom % 60) == 0;
      tick();
    end
    cnt_clr = 1'b0;
    drain();

    // Reset with two words in flight.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.code_in   = 21'h000020;
    tick();
    bus.code_in = 21'h020010;
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    q.delete();
    held_valid = 0;
    exp_corr   = 0;
    exp_unc    = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (8) tick();
    chk("no_stale_out", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
